// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory command/read-data port between the data cache
// (dc), instruction cache (ic) and graphics pixel fetcher (gp). One transaction
// is in flight at a time. Fixed priority dc > ic > gp, except that gp is
// promoted to the top once it has lost MAX_WAIT arbitrations while waiting.
module mem_arbiter #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter int BEATS    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dc_req_valid,
  input  logic                dc_req_rnw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wmask,
  output logic                dc_req_ready,
  input  logic                ic_req_valid,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  output logic                ic_req_ready,
  input  logic                gp_req_valid,
  input  logic [ADDR_W-1:0]   gp_req_addr,
  output logic                gp_req_ready,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic                mem_cmd_rnw,
  output logic [ADDR_W-1:0]   mem_cmd_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rdata_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                dc_rdata_valid,
  output logic                ic_rdata_valid,
  output logic                gp_rdata_valid,
  output logic [1:0]          owner
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX   = AGE_W'(MAX_WAIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DC   = 2'd1;
  localparam logic [1:0] OWN_IC   = 2'd2;
  localparam logic [1:0] OWN_GP   = 2'd3;

  typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;

  state_t              state, state_nxt;
  logic [1:0]          win;
  logic [AGE_W-1:0]    gp_age;
  logic [CNT_W-1:0]    beat_cnt;
  logic                accept, beat, last_beat;

  // Next-state, arbitration winner and handshake strobes.
  always_comb begin
    state_nxt     = state;
    win           = OWN_NONE;
    mem_cmd_valid = 1'b0;
    accept        = 1'b0;
    beat          = 1'b0;
    last_beat     = 1'b0;
    case (state)
      IDLE: begin
        if (gp_req_valid && gp_age == AGE_MAX) win = OWN_GP;
        else if (dc_req_valid)                 win = OWN_DC;
        else if (ic_req_valid)                 win = OWN_IC;
        else if (gp_req_valid)                 win = OWN_GP;
        if (win != OWN_NONE) state_nxt = CMD;
      end
      CMD: begin
        mem_cmd_valid = 1'b1;
        accept        = mem_cmd_ready;
        if (accept) state_nxt = mem_cmd_rnw ? RDATA : IDLE;
      end
      RDATA: begin
        beat      = mem_rdata_valid;
        last_beat = beat && (beat_cnt == LAST_BEAT);
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Owner, latched command payload, beat counter and gp aging counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= OWN_NONE;
      mem_cmd_rnw  <= 1'b0;
      mem_cmd_addr <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      beat_cnt     <= '0;
      gp_age       <= '0;
    end else begin
      if (state == IDLE && win != OWN_NONE) begin
        owner <= win;
        if (win == OWN_DC) begin
          mem_cmd_rnw  <= dc_req_rnw;
          mem_cmd_addr <= dc_req_addr;
          mem_wdata    <= dc_wdata;
          mem_wmask    <= dc_wmask;
        end else begin
          mem_cmd_rnw  <= 1'b1;
          mem_cmd_addr <= (win == OWN_IC) ? ic_req_addr : gp_req_addr;
          mem_wdata    <= '0;
          mem_wmask    <= '0;
        end
        // gp ages only while it is actually waiting and loses.
        if (win == OWN_GP)                        gp_age <= '0;
        else if (gp_req_valid && gp_age != AGE_MAX) gp_age <= gp_age + 1'b1;
      end
      if (accept) begin
        beat_cnt <= '0;
        if (!mem_cmd_rnw) owner <= OWN_NONE;
      end
      if (beat) beat_cnt <= beat_cnt + 1'b1;
      if (last_beat) owner <= OWN_NONE;
    end
  end

  assign dc_req_ready   = accept && owner == OWN_DC;
  assign ic_req_ready   = accept && owner == OWN_IC;
  assign gp_req_ready   = accept && owner == OWN_GP;

  // Beats are broadcast; only the owner's valid strobe is raised.
  assign rdata          = mem_rdata;
  assign dc_rdata_valid = beat && owner == OWN_DC;
  assign ic_rdata_valid = beat && owner == OWN_IC;
  assign gp_rdata_valid = beat && owner == OWN_GP;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-way arbiter that shares the single downstream memory command/read-data port between the data cache (dc), instruction cache (ic) and the graphics pixel fetcher (gp). It sits between the cache miss/fill logic and the memory controller. It serializes transactions, tracks the owner of each in-flight read burst and steers the returning beats to that owner. Priority is fixed, dc > ic > gp, with an aging counter that prevents gp starvation.

## Interface
- ADDR_W, 28, memory command address width (line-aligned address)
- DATA_W, 128, beat width; DATA_W/8 byte-mask bits
- BEATS, 4, read beats returned per read command (>=1)
- MAX_WAIT, 8, lost arbitrations before gp is promoted to top priority (>=1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dc_req_valid  in  1  dc request pending; held with payload until dc_req_ready
- dc_req_rnw  in  1  1 = read, 0 = write
- dc_req_addr  in  ADDR_W  dc address
- dc_wdata  in  DATA_W  single write beat
- dc_wmask  in  DATA_W/8  byte enables for the write
- dc_req_ready  out  1  one-cycle pulse when memory accepts the dc command
- ic_req_valid / ic_req_addr / ic_req_ready  in/in/out  1/ADDR_W/1  ic read request; same rules as dc, read only
- gp_req_valid / gp_req_addr / gp_req_ready  in/in/out  1/ADDR_W/1  gp read request; same rules, read only
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  memory accepts the command when valid & ready
- mem_cmd_rnw  out  1  command direction
- mem_cmd_addr  out  ADDR_W  command address
- mem_wdata / mem_wmask  out  DATA_W / DATA_W/8  write payload, valid with the command
- mem_rdata_valid  in  1  read beat valid; no back-pressure
- mem_rdata  in  DATA_W  read beat
- rdata  out  DATA_W  mem_rdata passed through to all requesters
- dc_rdata_valid / ic_rdata_valid / gp_rdata_valid  out  1 each  beat belongs to that requester
- owner  out  2  0 none, 1 dc, 2 ic, 3 gp; current transaction owner

## Operation
- FSM states: IDLE, CMD, RDATA.
- IDLE: if any req_valid, latch the winner into owner and its addr/rnw/wdata/wmask into command registers, then go to CMD. Otherwise owner=0.
- Winner order is dc, ic, gp. If gp_age == MAX_WAIT and gp_req_valid, gp wins outright.
- CMD: mem_cmd_valid=1 from the registers. On mem_cmd_ready, pulse the owner's req_ready for that cycle. A read then goes to RDATA with beat_cnt=0. A write returns to IDLE and sets owner=0 on the next cycle.
- RDATA: each mem_rdata_valid asserts the owner's rdata_valid combinationally in the same cycle and increments beat_cnt. On beat BEATS-1, go to IDLE and set owner=0.
- gp_age is a saturating counter (0..MAX_WAIT).
  - +1 on each IDLE grant to dc or ic while gp_req_valid=1.
  - Cleared on a grant to gp.
  - Unchanged when gp_req_valid=0.
- mem_rdata_valid arriving in IDLE or CMD is ignored: no rdata_valid is raised and beat_cnt is unchanged.
- Request payload changes while valid=1 are ignored; the payload is captured at grant.
- Requesters that drop valid before ready still complete the already-latched command.
- No request is granted while a transaction is outstanding: one transaction at a time.

## Timing
- Reset values: state IDLE, owner=0, gp_age=0, beat_cnt=0, mem_cmd_valid=0, all req_ready=0, all rdata_valid=0, mem_cmd_addr/wdata/wmask/rnw=0.
- Reset is honored in any state, including mid-burst. Beats still returned afterwards are dropped per the IDLE rule.
- Grant latency: req_valid rises in cycle 0 while IDLE → mem_cmd_valid=1 in cycle 1.
- If mem_cmd_ready=1 in cycle 1: req_ready pulses in cycle 1.
  - Write: back in IDLE in cycle 2, so the next grant is at cycle 2 and the next command at cycle 3.
  - Read: RDATA from cycle 2.
- mem_cmd_* are registered and stable while mem_cmd_valid=1 and mem_cmd_ready=0.
- rdata_valid has zero latency from mem_rdata_valid.
- After the last read beat in cycle N: IDLE in N+1, the next command can be valid in N+2.
- The arbiter adds 1 idle cycle between transactions.

## Test plan
- ic single read, BEATS=4, mem_cmd_ready=1: ic_req_ready pulses in cycle 1 with addr 0x0000100, mem_cmd_rnw=1. Four beats 0xA..0xD produce exactly four ic_rdata_valid pulses, and owner returns to 0.
- dc write, addr 0x0000040, wdata 0x1122..FF, wmask 0x00F0: mem_cmd matches the payload exactly, dc_req_ready pulses once, no RDATA state, owner=0 the cycle after acceptance.
- dc, ic and gp all valid at cycle 0 and held: commands are issued in order dc, ic, gp. Each read's beats assert only the matching *_rdata_valid.
- MAX_WAIT=2, gp and ic held valid continuously, dc re-requesting after each completion: gp loses twice (gp_age=2) and is granted third, ahead of a pending dc. gp_age then returns to 0.
- mem_cmd_ready held low for 5 cycles: mem_cmd_valid and the payload stay stable, no req_ready pulses, and exactly one acceptance occurs when ready rises.
- rst asserted after beat 2 of a gp read: all outputs take reset values on the next cycle. The remaining 2 beats raise no rdata_valid, and a new ic request is then served normally.
